// File: rtl/ll_rx_pkg.sv
// ll_rx_pkg: shared types and constants for the LocalLink frame receiver.
// Holds the FSM state enum, header length and expected header fields,
// error codes, the payload limit, counter width and a header-byte lookup.
package ll_rx_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  localparam int HDR_LEN = 14;
  localparam int CNT_W = 16;
  localparam int MAX_PAYLOAD = 1420;
  localparam logic [47:0] DST_MAC = 48'hda0203040506;
  localparam logic [47:0] SRC_MAC = 48'h002b67beceaa;
  localparam logic [15:0] ETHERTYPE = 16'h0800;
  localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR = 2'd1;
  localparam logic [1:0] ERR_RUNT = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;
  // Header byte idx (0..13) on the wire, most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    return HDR_BYTES[{4'd13 - idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ll_byte_packer.sv
// ll_byte_packer: packs payload bytes into 32-bit words, low byte first.
// Ports: i_valid/i_data/i_last payload byte in (i_last flushes a partial
// word, zero padded); i_clr discards an incomplete partial word;
// o_word/o_valid/o_last/o_bytes with i_ready form the output handshake;
// o_rdy is low only when a finished word waits behind a stalled output.
module ll_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  input  logic        i_clr,
  input  logic        i_ready,
  output logic        o_rdy,
  output logic [31:0] o_word,
  output logic        o_valid,
  output logic        o_last,
  output logic [2:0]  o_bytes
);
  logic [31:0] r_stg, r_word;
  logic [2:0] r_cnt, r_bytes;
  logic r_done, r_slast, r_valid, r_last;
  logic w_free, w_move, w_cmp, w_direct;
  logic [31:0] w_bword, w_mword;
  logic [2:0] w_bcnt, w_mcnt;
  assign w_free = !r_valid || i_ready;
  // A finished staged word moves out first; the staging slot is then free.
  assign w_move = r_done && w_free;
  assign w_bword = r_done ? 32'd0 : r_stg;
  assign w_bcnt = r_done ? 3'd0 : r_cnt;
  assign w_mword = w_bword | (32'(i_data) << {w_bcnt[1:0], 3'b000});
  assign w_mcnt = w_bcnt + 3'd1;
  assign w_cmp = i_valid && (w_mcnt == 3'd4 || i_last);
  // Completing byte bypasses staging so a word appears the next cycle.
  assign w_direct = w_cmp && w_free && !w_move;
  assign o_rdy = !r_done || w_free;
  assign o_word = r_word;
  assign o_valid = r_valid;
  assign o_last = r_last;
  assign o_bytes = r_bytes;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_stg, r_cnt, r_done, r_slast} <= '0;
      {r_word, r_bytes, r_last, r_valid} <= '0;
    end else begin
      if (w_move) {r_word, r_bytes, r_last, r_valid} <= {r_stg, r_cnt, r_slast, 1'b1};
      else if (w_direct) {r_word, r_bytes, r_last, r_valid} <= {w_mword, w_mcnt, i_last, 1'b1};
      else if (i_ready) r_valid <= 1'b0;
      if (w_cmp && !w_direct) {r_stg, r_cnt, r_done, r_slast} <= {w_mword, w_mcnt, 1'b1, i_last};
      else if (i_valid && !w_cmp) {r_stg, r_cnt, r_done, r_slast} <= {w_mword, w_mcnt, 2'b00};
      else if (w_cmp || w_move || (i_clr && !r_done)) {r_stg, r_cnt, r_done, r_slast} <= '0;
    end
  end
endmodule

// File: rtl/ll_frame_rx.sv
// ll_frame_rx: LocalLink receive frame consumer; checks/strips the 14-byte
// Ethernet header and emits payload as 32-bit low-byte-first words.
// Ports: clk/rst; ll_data/ll_sof/ll_eof/ll_src_rdy/ll_dst_rdy byte stream;
// word_out/word_valid/word_last/word_bytes/word_ready word stream;
// frame_done/frame_err pulses, err_code, frame_cnt/drop_cnt debug status.
// LL_RX_CHECK_MAC_EN: when defined the header is compared against the
// expected MAC/type and mismatches are dropped; otherwise it is only stripped.
module ll_frame_rx
  import ll_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ll_data,
  input  logic             ll_sof,
  input  logic             ll_eof,
  input  logic             ll_src_rdy,
  output logic             ll_dst_rdy,
  output logic [31:0]      word_out,
  output logic             word_valid,
  output logic             word_last,
  output logic [2:0]       word_bytes,
  input  logic             word_ready,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  state_t r_state;
  logic [3:0] r_hcnt;
  logic [10:0] r_pcnt;
  logic r_en, r_done, r_err;
  logic [1:0] r_code;
  logic [CNT_W-1:0] r_fcnt, r_dcnt;
  logic w_pk_rdy, w_acc, w_abort, w_hbyte, w_mis, w_runt, w_ovf, w_pk_valid, w_good;
  logic [3:0] w_idx;
  logic [1:0] w_nerr;
  // r_en holds ll_dst_rdy low through reset and its first following cycle.
  assign ll_dst_rdy = r_en && w_pk_rdy;
  assign w_acc = ll_src_rdy && ll_dst_rdy;
  assign w_abort = w_acc && ll_sof && (r_state == HDR || r_state == PAYLOAD);
  // Any sof outside DROP starts a header at byte 0, including an abort byte.
  assign w_hbyte = w_acc && r_state != DROP && (ll_sof || r_state == HDR);
  assign w_idx = ll_sof ? 4'd0 : r_hcnt;
`ifdef LL_RX_CHECK_MAC_EN
  assign w_mis = w_hbyte && ll_data != hdr_byte(w_idx);
`else
  assign w_mis = 1'b0;
`endif
  assign w_runt = w_hbyte && ll_eof && !w_mis;
  assign w_ovf = w_acc && r_state == PAYLOAD && !ll_sof && r_pcnt == 11'(MAX_PAYLOAD);
  assign w_pk_valid = w_acc && r_state == PAYLOAD && !ll_sof && !w_ovf;
  assign w_good = w_pk_valid && ll_eof;
  // An abort and a fault on the new frame's first byte are two dropped frames.
  assign w_nerr = {1'b0, w_abort} + {1'b0, w_mis || w_runt || w_ovf};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hcnt <= '0;
      r_pcnt <= '0;
      {r_en, r_done, r_err} <= '0;
      r_code <= ERR_NONE;
      r_fcnt <= '0;
      r_dcnt <= '0;
    end else begin
      r_en <= 1'b1;
      r_done <= w_good;
      r_err <= w_nerr != 2'd0;
      r_fcnt <= r_fcnt + CNT_W'(w_good);
      r_dcnt <= r_dcnt + CNT_W'(w_nerr);
      if (w_mis) r_code <= ERR_HDR;
      else if (w_runt) r_code <= ERR_RUNT;
      else if (w_ovf || w_abort) r_code <= ERR_OVF;
      if (w_hbyte) begin
        r_hcnt <= w_idx + 4'd1;
        r_pcnt <= '0;
        r_state <= w_mis ? (ll_eof ? IDLE : DROP) : w_runt ? IDLE :
                   (w_idx == 4'(HDR_LEN - 1)) ? PAYLOAD : HDR;
      end else if (w_ovf) r_state <= ll_eof ? IDLE : DROP;
      else if (w_pk_valid) begin
        r_pcnt <= r_pcnt + 11'd1;
        if (ll_eof) r_state <= IDLE;
      end else if (w_acc && r_state == DROP && ll_eof) r_state <= IDLE;
    end
  end
  ll_byte_packer u_pack (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_pk_valid),
    .i_data  (ll_data),
    .i_last  (ll_eof),
    .i_clr   (w_abort || w_ovf),
    .i_ready (word_ready),
    .o_rdy   (w_pk_rdy),
    .o_word  (word_out),
    .o_valid (word_valid),
    .o_last  (word_last),
    .o_bytes (word_bytes)
  );
  assign frame_done = r_done;
  assign frame_err = r_err;
  assign err_code = r_code;
  assign frame_cnt = r_fcnt;
  assign drop_cnt = r_dcnt;
endmodule

// File: tb/tb_ll_frame_rx.sv
// tb_ll_frame_rx: scoreboard bench for ll_frame_rx with a frame-level model.
module tb_ll_frame_rx;
  logic clk = 0, rst = 1;
  logic [7:0] ll_data = 0;
  logic ll_sof = 0, ll_eof = 0, ll_src_rdy = 0, word_ready = 0;
  logic ll_dst_rdy, word_valid, word_last, frame_done, frame_err;
  logic [31:0] word_out;
  logic [2:0] word_bytes;
  logic [1:0] err_code;
  logic [15:0] frame_cnt, drop_cnt;

  ll_frame_rx dut (
    .clk(clk), .rst(rst), .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof),
    .ll_src_rdy(ll_src_rdy), .ll_dst_rdy(ll_dst_rdy), .word_out(word_out),
    .word_valid(word_valid), .word_last(word_last), .word_bytes(word_bytes),
    .word_ready(word_ready), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic [2:0] b; logic l; } wexp_t;
  typedef struct { logic k; logic [1:0] code; logic [15:0] cnt; } eexp_t;
  wexp_t wq[$];
  eexp_t eq[$];
  logic [7:0] fb[$];
  logic [7:0] hdr [14] = '{8'hda, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h00, 8'h2b, 8'h67, 8'hbe, 8'hce, 8'haa, 8'h08, 8'h00};
  int checks = 0, errors = 0;
  logic [15:0] m_fcnt = 0, m_dcnt = 0;
  bit rand_rdy = 0, hold_low = 0, gap_en = 0, chk_coinc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level reference: outcome from header match, length and termination.
  task automatic push_err(input logic [1:0] code);
    m_dcnt++;
    eq.push_back('{k: 1'b1, code: code, cnt: m_dcnt});
  endtask

  task automatic push_words(input int np, input bit with_last);
    for (int i = 0; i < np; i += 4) begin
      int nb = (np - i < 4) ? np - i : 4;
      logic [31:0] w = 0;
      if (!with_last && nb < 4) break;
      for (int j = 0; j < nb; j++) w[8*j +: 8] = fb[14 + i + j];
      wq.push_back('{w: w, b: 3'(nb), l: with_last && (i + 4 >= np)});
    end
  endtask

  task automatic model(input bit by_eof);
    int n = fb.size();
    int np = n - 14;
    bit mis = 0;
`ifdef LL_RX_CHECK_MAC_EN
    for (int i = 0; i < n && i < 14; i++) if (fb[i] !== hdr[i]) mis = 1;
`endif
    if (mis) push_err(2'd1);
    else if (n <= 14) push_err(by_eof ? 2'd2 : 2'd3);
    else if (np > 1420) begin push_words(1420, 0); push_err(2'd3); end
    else if (!by_eof) begin push_words(np, 0); push_err(2'd3); end
    else begin
      push_words(np, 1);
      m_fcnt++;
      eq.push_back('{k: 1'b0, code: 2'd0, cnt: m_fcnt});
    end
  endtask

  task automatic build(input int hlen, input int plen);
    fb.delete();
    for (int i = 0; i < hlen; i++) fb.push_back(hdr[i]);
    for (int i = 0; i < plen; i++) fb.push_back(8'($urandom));
  endtask

  // Called and returns at posedge+1; acceptance is judged at the negedge.
  task automatic send_byte(input logic [7:0] d, input bit s, input bit e);
    bit acc = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin ll_src_rdy = 0; @(posedge clk); #1; end
    ll_data = d; ll_sof = s; ll_eof = e; ll_src_rdy = 1;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk); acc = ll_dst_rdy;
      @(posedge clk); #1;
    end
    if (!acc) begin checks++; errors++; $display("FAIL byte_accept_timeout: byte %h never accepted", d); end
    ll_src_rdy = 0; ll_sof = 0; ll_eof = 0;
  endtask

  task automatic send_fb(input bit eof_last);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], i == 0, eof_last && i == fb.size() - 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((wq.size() != 0 || eq.size() != 0) && t < 5000) begin @(posedge clk); #1; t++; end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words and %0d events still expected", wq.size(), eq.size());
      wq.delete(); eq.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial forever begin
    @(posedge clk); #1;
    word_ready = hold_low ? 1'b0 : rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  wexp_t me;
  eexp_t mv;
  logic [31:0] p_word;
  logic p_stall = 0;
  always @(negedge clk) begin
    if (rst) p_stall = 0;
    else begin
      if (p_stall) check("hold_stable", word_out, p_word);
      if (word_valid && word_ready) begin
        if (wq.size() == 0) begin checks++; errors++; $display("FAIL extra_word: got %h with none expected", word_out); end
        else begin
          me = wq.pop_front();
          check("word_out", word_out, me.w);
          check("word_bytes", 32'(word_bytes), 32'(me.b));
          check("word_last", 32'(word_last), 32'(me.l));
        end
      end
      if (frame_done) begin
        if (eq.size() == 0 || eq[0].k) begin checks++; errors++; $display("FAIL frame_done: got pulse, expected none"); end
        else begin
          mv = eq.pop_front();
          check("frame_cnt", 32'(frame_cnt), 32'(mv.cnt));
          if (chk_coinc) check("done_with_last", {30'd0, word_valid, word_last}, 32'd3);
        end
      end
      if (frame_err) begin
        if (eq.size() == 0 || !eq[0].k) begin checks++; errors++; $display("FAIL frame_err: got pulse code %0d, expected none", err_code); end
        else begin
          mv = eq.pop_front();
          check("err_code", 32'(err_code), 32'(mv.code));
          check("drop_cnt", 32'(drop_cnt), 32'(mv.cnt));
        end
      end
      p_stall = word_valid && !word_ready;
      p_word = word_out;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outputs", {word_out, 16'd0} | {16'd0, frame_cnt | drop_cnt}, 32'd0);
    check("rst_flags", {25'd0, ll_dst_rdy, word_valid, word_last, frame_done, frame_err, err_code}, 32'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk); check("dst_rdy_first_cycle", 32'(ll_dst_rdy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("dst_rdy_after_rst", 32'(ll_dst_rdy), 32'd1);
    @(posedge clk); #1;

    // reset mid-frame: partial frame and partial word are lost
    build(14, 3); send_fb(0);
    rst = 1; @(posedge clk); #1;
    @(negedge clk); check("midrst_dst_rdy", 32'(ll_dst_rdy), 32'd0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    @(negedge clk); check("midrst_state", {word_valid, frame_cnt, err_code}, 32'd0);
    @(posedge clk); #1;

    // good frame 00..05
    fb.delete();
    for (int i = 0; i < 14; i++) fb.push_back(hdr[i]);
    for (int i = 0; i < 6; i++) fb.push_back(8'(i));
    chk_coinc = 1; model(1); send_fb(1); wait_idle(); chk_coinc = 0;
    check("good_frame_cnt", 32'(frame_cnt), 32'd1);

    // header mismatch on the first byte
    build(14, 8); fb[0] = 8'hdb; model(1); send_fb(1); wait_idle();
    // runt: sof plus 5 header bytes, eof on the last
    build(6, 0); model(1); send_fb(1); wait_idle();
    check("runt_code", 32'(err_code), 32'd2);
    // overflow: 1421 payload bytes
    build(14, 1421); model(1); send_fb(1); wait_idle();
    check("ovf_code", 32'(err_code), 32'd3);

    // backpressure: output stalls, 4 more bytes fill staging, then input stops
    hold_low = 1;
    build(14, 20); model(1);
    for (int i = 0; i < 22; i++) send_byte(fb[i], i == 0, 1'b0);
    @(negedge clk); check("bp_dst_rdy_low", 32'(ll_dst_rdy), 32'd0);
    @(posedge clk); #1;
    ll_data = fb[22]; ll_src_rdy = 1; cnt = 0;
    repeat (10) begin @(negedge clk); if (ll_dst_rdy) cnt++; @(posedge clk); #1; end
    ll_src_rdy = 0;
    check("bp_no_accept", 32'(cnt), 32'd0);
    hold_low = 0;
    for (int i = 22; i < 34; i++) send_byte(fb[i], 1'b0, i == 33);
    wait_idle();

    // abort at payload byte 7, then a good frame
    build(14, 7); model(0); send_fb(0);
    build(14, 10); model(1); send_fb(1); wait_idle();

    // randomized frames with gaps and random downstream readiness
    rand_rdy = 1; gap_en = 1;
    for (int f = 0; f < 25; f++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 9) repeat ($urandom_range(1, 2)) send_byte(8'($urandom), 1'b0, 1'b0);
      if (kind == 6) begin build($urandom_range(1, 14), 0); model(1); send_fb(1); end
      else if (kind == 7) begin
        build(14, $urandom_range(1, 20));
        fb[$urandom_range(0, 13)] ^= 8'($urandom_range(1, 255));
        model(1); send_fb(1);
      end else if (kind == 8) begin
        int n = $urandom_range(1, 30);
        build(n < 14 ? n : 14, n < 14 ? 0 : n - 14); model(0); send_fb(0);
        build(14, $urandom_range(1, 40)); model(1); send_fb(1);
      end else begin build(14, $urandom_range(1, 40)); model(1); send_fb(1); end
    end
    rand_rdy = 0; gap_en = 0;
    wait_idle();
    check("final_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check("final_drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
